// File: rtl/histogram_eq_lut_pkg.sv
// Shared definitions for the histogram-equalisation LUT builder: width helper,
// default geometry with its derived widths, and the build FSM encoding.
package histogram_eq_lut_pkg;

  // Number of bits needed to represent value (0 for value 0).
  function automatic int clogb2(input int value);
    int bits;
    bits = 0;
    while (value > 0) begin
      bits++;
      value = value >> 1;
    end
    return bits;
  endfunction

  // Default geometry; the top re-derives the same quantities from its own parameters.
  localparam int DEF_PIXEL_WIDTH  = 8;
  localparam int DEF_IMAGE_WIDTH  = 640;
  localparam int DEF_IMAGE_HEIGHT = 480;
  localparam int DEF_COLOR_RANGE  = 256;

  localparam int TOTAL_PIXEL   = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  localparam int DATA_WIDTH    = clogb2(TOTAL_PIXEL - 1);
  localparam int ADDRESS_WIDTH = clogb2(DEF_COLOR_RANGE - 1);
  localparam int CDF_WIDTH     = DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DIV,
    WR,
    CLR
  } state_t;

endpackage

// File: rtl/histogram_eq_lut_if.sv
// Histogram counter read/clear port. The LUT builder is the master: it issues
// bin addresses, read requests and the clear pulse; the counter answers.
interface histogram_eq_lut_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 19
);
  logic [ADDRESS_WIDTH-1:0] hist_addr;
  logic                     hist_rreq;
  logic [DATA_WIDTH-1:0]    hist_data;
  logic                     hist_valid;
  logic                     hist_clear;

  modport master (
    output hist_addr, hist_rreq, hist_clear,
    input  hist_data, hist_valid
  );

  modport slave (
    input  hist_addr, hist_rreq, hist_clear,
    output hist_data, hist_valid
  );
endinterface

// File: rtl/histogram_eq_lut_div.sv
// Iterative restoring divider by a constant. Produces Q_WIDTH quotient bits,
// MSB first, one per cycle after start. The caller guarantees the quotient fits
// in Q_WIDTH bits, so numerator >> Q_WIDTH is already below DIVISOR and can seed
// the partial remainder directly. done is high during the final iteration; the
// complete quotient is on the output from the following cycle.
module hist_const_div
  import histogram_eq_lut_pkg::*;
#(
  parameter int DIVISOR   = 16,
  parameter int NUM_WIDTH = 8,
  parameter int Q_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] numerator,
  output logic                 done,
  output logic [Q_WIDTH-1:0]   quotient
);

  localparam int R_WIDTH = clogb2(DIVISOR) + 1;
  localparam int C_WIDTH = clogb2(Q_WIDTH);

  logic [R_WIDTH-1:0] rem;
  logic [Q_WIDTH-1:0] low;
  logic [C_WIDTH-1:0] cnt;
  logic [R_WIDTH-1:0] trial;
  logic               fits;

  // Shift the next numerator bit into the remainder and test against the divisor.
  assign trial = {rem[R_WIDTH-2:0], low[Q_WIDTH-1]};
  assign fits  = (trial >= R_WIDTH'(DIVISOR));
  assign done  = (cnt == C_WIDTH'(1));

  // One restoring step per cycle while iterations remain.
  // NOTE: registered state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rem      <= '0;
      low      <= '0;
      cnt      <= '0;
      quotient <= '0;
    end else if (start) begin
      rem <= R_WIDTH'(numerator >> Q_WIDTH);
      low <= numerator[Q_WIDTH-1:0];
      cnt <= C_WIDTH'(Q_WIDTH);
    end else if (cnt != '0) begin
      rem      <= fits ? (trial - R_WIDTH'(DIVISOR)) : trial;
      low      <= low << 1;
      quotient <= Q_WIDTH'({quotient, fits});
      cnt      <= cnt - C_WIDTH'(1);
    end
  end

endmodule

// File: rtl/histogram_eq_lut.sv
// Histogram-equalisation LUT builder. On start it walks every histogram bin,
// accumulates a saturating CDF, maps each bin to cdf*(COLOR_RANGE-1)/TOTAL_PIXEL
// and stores it in an internal LUT. Live pixels are remapped through the LUT
// with one cycle of latency (identity until the first build completes).
module histogram_eq_lut
  import histogram_eq_lut_pkg::*;
#(
  parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int COLOR_RANGE  = DEF_COLOR_RANGE,
  parameter bit CLEAR_AFTER  = 1'b1
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  histogram_eq_lut_if.master     hist,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  input  logic                   pixel_valid,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   pixel_out_valid
);

  localparam int TOTAL      = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int D_WIDTH    = clogb2(TOTAL - 1);
  localparam int A_WIDTH    = clogb2(COLOR_RANGE - 1);
  localparam int C_WIDTH    = D_WIDTH + 1;
  localparam int NUM_WIDTH  = C_WIDTH + A_WIDTH;

  state_t                 state;
  logic [C_WIDTH-1:0]     cdf;
  logic [C_WIDTH-1:0]     cdf_sum;
  logic [C_WIDTH-1:0]     cdf_sat;
  logic [A_WIDTH-1:0]     idx;
  logic                   lut_ready;
  logic [NUM_WIDTH-1:0]   numerator;
  logic                   div_start;
  logic                   div_done;
  logic [A_WIDTH-1:0]     quotient;
  logic [PIXEL_WIDTH-1:0] lut [COLOR_RANGE];

  // Saturating CDF update; the cap keeps every quotient within COLOR_RANGE-1.
  assign cdf_sum   = cdf + C_WIDTH'(hist.hist_data);
  assign cdf_sat   = (cdf_sum > C_WIDTH'(TOTAL)) ? C_WIDTH'(TOTAL) : cdf_sum;
  assign numerator = NUM_WIDTH'(cdf_sat) * NUM_WIDTH'(COLOR_RANGE - 1);
  assign div_start = (state == WAIT) && hist.hist_valid;

  hist_const_div #(
    .DIVISOR   (TOTAL),
    .NUM_WIDTH (NUM_WIDTH),
    .Q_WIDTH   (A_WIDTH)
  ) u_div (
    .clk       (clk),
    .arst      (arst),
    .start     (div_start),
    .numerator (numerator),
    .done      (div_done),
    .quotient  (quotient)
  );

  // Build FSM: request, wait, divide and write each bin, then clear and finish.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state           <= IDLE;
      cdf             <= '0;
      idx             <= '0;
      lut_ready       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      hist.hist_addr  <= '0;
      hist.hist_rreq  <= 1'b0;
      hist.hist_clear <= 1'b0;
    end else begin
      done            <= 1'b0;
      hist.hist_rreq  <= 1'b0;
      hist.hist_clear <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state          <= REQ;
          cdf            <= '0;
          idx            <= '0;
          busy           <= 1'b1;
          hist.hist_addr <= '0;
          hist.hist_rreq <= 1'b1;
        end
        REQ:  state <= WAIT;
        WAIT: if (hist.hist_valid) begin
          cdf   <= cdf_sat;
          state <= DIV;
        end
        DIV:  if (div_done) state <= WR;
        WR: begin
          if (idx == A_WIDTH'(COLOR_RANGE - 1)) begin
            if (CLEAR_AFTER) begin
              state           <= CLR;
              hist.hist_clear <= 1'b1;
            end else begin
              state     <= IDLE;
              done      <= 1'b1;
              busy      <= 1'b0;
              lut_ready <= 1'b1;
            end
          end else begin
            idx            <= idx + A_WIDTH'(1);
            hist.hist_addr <= idx + A_WIDTH'(1);
            hist.hist_rreq <= 1'b1;
            state          <= REQ;
          end
        end
        CLR: begin
          state     <= IDLE;
          done      <= 1'b1;
          busy      <= 1'b0;
          lut_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // LUT write port, driven by the WR state.
  // NOTE: the LUT array has no reset; lut_ready gates its use, and resetting it would forbid RAM mapping.
  always_ff @(posedge clk) begin
    if (state == WR) lut[idx] <= PIXEL_WIDTH'(quotient);
  end

  // One-cycle lookup; a same-cycle write to the same bin is seen on the next lookup.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
    end else begin
      pixel_out_valid <= pixel_valid;
      pixel_out       <= lut_ready ? lut[pixel_in] : pixel_in;
    end
  end

endmodule

// File: tb/tb_histogram_eq_lut.sv
// Bench for histogram_eq_lut on a 4x4 image, 8 bins, 3-bit pixels. A histogram
// model answers reads (latency 1, or longer per bin); expected lookup results
// are queued when pixels are driven and compared when pixel_out_valid appears.
module tb_histogram_eq_lut;

  localparam int PW    = 3;
  localparam int CR    = 8;
  localparam int TOTAL = 16;
  localparam int AW    = 3;
  localparam int DW    = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic          start;
  logic          busy;
  logic          done;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid;
  logic [PW-1:0] pixel_out;
  logic          pixel_out_valid;

  histogram_eq_lut_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) hist ();

  histogram_eq_lut #(
    .PIXEL_WIDTH  (PW),
    .IMAGE_WIDTH  (4),
    .IMAGE_HEIGHT (4),
    .COLOR_RANGE  (CR),
    .CLEAR_AFTER  (1'b1)
  ) dut (
    .clk             (clk),
    .arst            (arst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .hist            (hist),
    .pixel_in        (pixel_in),
    .pixel_valid     (pixel_valid),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int hist_mem [CR];
  int lat      [CR];
  int exp_lut  [CR];
  int exp_q    [$];
  int addr_log [$];
  int rreq_count  = 0;
  int done_count  = 0;
  int clear_count = 0;
  int cyc         = 0;
  int clear_cyc   = -1;
  int done_cyc    = -1;
  bit bin4_req    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Histogram model and output monitors, all sampled on the falling edge.
  initial begin
    int pend;
    int pend_addr;
    pend            = 0;
    pend_addr       = 0;
    hist.hist_valid = 1'b0;
    hist.hist_data  = '0;
    forever begin
      @(negedge clk);
      hist.hist_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          hist.hist_valid = 1'b1;
          hist.hist_data  = DW'(hist_mem[pend_addr]);
        end
      end
      if (hist.hist_rreq === 1'b1) begin
        rreq_count++;
        pend_addr = int'(hist.hist_addr);
        pend      = lat[pend_addr];
        addr_log.push_back(pend_addr);
        if (pend_addr == 4) bin4_req = 1'b1;
      end
      if (done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
      if (hist.hist_clear === 1'b1) begin
        clear_count++;
        clear_cyc = cyc;
      end
      if (pixel_out_valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_pixel_out", 1, 0);
        else check("pixel_out", pixel_out, exp_q.pop_front());
      end
    end
  end

  // Reference mapping: saturating CDF scaled to the bin range.
  task automatic compute_expected();
    int cdf;
    cdf = 0;
    for (int i = 0; i < CR; i++) begin
      cdf += hist_mem[i];
      if (cdf > TOTAL) cdf = TOTAL;
      exp_lut[i] = cdf * (CR - 1) / TOTAL;
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < CR; i++) exp_lut[i] = i;
  endtask

  // Drive every pixel value once and require the mapped result.
  task automatic sweep(input string tag);
    for (int p = 0; p < CR; p++) begin
      @(negedge clk);
      pixel_in    = PW'(p);
      pixel_valid = 1'b1;
      exp_q.push_back(exp_lut[p]);
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_results_drained"}, exp_q.size(), 0);
  endtask

  // One LUT build; optionally pulse start again while busy.
  task automatic build(input string tag, input bit restart);
    rreq_count  = 0;
    done_count  = 0;
    clear_count = 0;
    addr_log.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (restart) begin
      repeat (3) @(negedge clk);
      check({tag, "_busy_mid"}, busy, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_count > 0) break;
    end
    repeat (6) @(negedge clk);
    check({tag, "_done_pulses"}, done_count, 1);
    check({tag, "_clear_pulses"}, clear_count, 1);
    check({tag, "_clear_before_done"}, done_cyc - clear_cyc, 1);
    check({tag, "_rreq_pulses"}, rreq_count, CR);
    for (int i = 0; i < CR; i++)
      check({tag, "_rreq_addr"}, (i < addr_log.size()) ? addr_log[i] : -1, i);
    check({tag, "_busy_after"}, busy, 0);
    compute_expected();
    sweep(tag);
  endtask

  initial begin
    arst        = 1'b1;
    start       = 1'b0;
    pixel_in    = '0;
    pixel_valid = 1'b0;
    for (int i = 0; i < CR; i++) begin
      hist_mem[i] = 0;
      lat[i]      = 1;
    end

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rreq", hist.hist_rreq, 0);
    check("reset_clear", hist.hist_clear, 0);
    check("reset_addr", hist.hist_addr, 0);
    check("reset_pix_valid", pixel_out_valid, 0);
    check("reset_pix_out", pixel_out, 0);
    arst = 1'b0;

    // Identity lookup before any build.
    @(negedge clk);
    pixel_in    = 3'd5;
    pixel_valid = 1'b1;
    exp_q.push_back(5);
    @(negedge clk);
    pixel_valid = 1'b0;
    check("identity_valid", pixel_out_valid, 1);
    repeat (2) @(negedge clk);
    check("identity_drained", exp_q.size(), 0);

    // Everything at bin 2: a 4-bit bin count tops out at 15, so bin 1 supplies
    // the 16th pixel; the CDF reaches TOTAL at bin 2. Expected LUT 0,0,7,7,7,7,7,7.
    hist_mem = '{0, 1, 15, 0, 0, 0, 0, 0};
    build("single", 1'b0);
    check("single_lut2", exp_lut[2], 7);
    @(negedge clk);
    pixel_in    = 3'd3;
    pixel_valid = 1'b1;
    exp_q.push_back(7);
    @(negedge clk);
    pixel_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("single_p3_drained", exp_q.size(), 0);

    // Uniform histogram: identity mapping 0..7.
    hist_mem = '{2, 2, 2, 2, 2, 2, 2, 2};
    build("uniform", 1'b0);

    // Oversubscribed histogram (total 40): CDF saturates at 16.
    hist_mem = '{5, 5, 5, 5, 5, 5, 5, 5};
    build("saturate", 1'b0);

    // Second start while busy is ignored; bin 3 answers 10 cycles late.
    hist_mem = '{2, 2, 2, 2, 2, 2, 2, 2};
    lat[3]   = 10;
    build("restart_slow", 1'b1);
    lat[3]   = 1;

    // Reset during the divide phase of bin 4 aborts the build.
    bin4_req = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (bin4_req) break;
      @(negedge clk);
    end
    check("abort_reached_bin4", bin4_req, 1);
    repeat (2) @(negedge clk);
    arst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rreq", hist.hist_rreq, 0);
    check("abort_clear", hist.hist_clear, 0);
    @(negedge clk);
    arst = 1'b0;
    set_identity();
    sweep("abort_identity");

    // A fresh build after the abort completes normally.
    hist_mem = '{0, 1, 15, 0, 0, 0, 0, 0};
    build("after_abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
